// File: rtl/i2c_cmd_pkg.sv
// i2c_cmd_pkg: shared types and widths for the i2c_cmd_queue command sequencer.
package i2c_cmd_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: synchronous FIFO with full/empty/level; pushes into a full FIFO are dropped.
module i2c_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign push_ok = push_i & !full_o;
  assign pop_ok  = pop_i & !empty_o;
  assign rdata_o = mem[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q + 1'b1;
      level_q <= level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/i2c_cmd_queue.sv
// i2c_cmd_queue: buffers host I2C requests and issues them one at a time to i2c_controller.
// Optional watchdog abort enabled by defining I2C_CMD_TIMEOUT_EN.
module i2c_cmd_queue
  import i2c_cmd_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_rw,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic [ADDR_W-1:0]        ctrl_addr,
  output logic [DATA_W-1:0]        ctrl_data_in,
  output logic                     ctrl_rw,
  output logic                     ctrl_enable,
  input  logic                     ctrl_ready,
  input  logic [DATA_W-1:0]        ctrl_data_out,
  output logic                     timeout_err
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("i2c_cmd_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end
  state_e            state_q, state_d;
  cmd_t              push_cmd, head;
  logic              full, empty, pop;
  logic [ADDR_W-1:0] ctrl_addr_q, ctrl_addr_d, rsp_addr_q, rsp_addr_d;
  logic [DATA_W-1:0] ctrl_data_q, ctrl_data_d, rsp_data_q, rsp_data_d;
  logic              ctrl_rw_q, ctrl_rw_d, ctrl_en_q, ctrl_en_d;
  logic              rsp_valid_q, rsp_valid_d;
  assign push_cmd = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
  i2c_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid),
    .pop_i   (pop),
    .wdata_i (push_cmd),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
  assign cmd_ready    = !full;
  assign busy         = (state_q != IDLE) | (level != '0);
  assign ctrl_addr    = ctrl_addr_q;
  assign ctrl_data_in = ctrl_data_q;
  assign ctrl_rw      = ctrl_rw_q;
  assign ctrl_enable  = ctrl_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_addr     = rsp_addr_q;
`ifdef I2C_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    ctrl_addr_d = ctrl_addr_q;
    ctrl_data_d = ctrl_data_q;
    ctrl_rw_d   = ctrl_rw_q;
    ctrl_en_d   = ctrl_en_q;
    rsp_valid_d = rsp_valid_q & !rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    unique case (state_q)
      IDLE: begin
        // a read may only start once the response slot is free, so captures never collide
        if (!empty && ctrl_ready && (!head.rw || !rsp_valid_q)) begin
          pop         = 1'b1;
          ctrl_addr_d = head.addr;
          ctrl_data_d = head.wdata;
          ctrl_rw_d   = head.rw;
          ctrl_en_d   = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!ctrl_ready) begin
          ctrl_en_d = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: state_d = ctrl_ready ? DONE : WAIT;
      DONE: begin
        if (ctrl_rw_q) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = ctrl_data_out;
          rsp_addr_d  = ctrl_addr_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef I2C_CMD_TIMEOUT_EN
    tmo_d = tmo_q;
    cnt_d = (state_d != state_q || !(state_q == ISSUE || state_q == WAIT)) ? '0 : cnt_q + 1'b1;
    if ((state_q == ISSUE || state_q == WAIT) && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      ctrl_en_d = 1'b0;
      tmo_d     = 1'b1;
      cnt_d     = '0;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_addr_q <= '0;
      ctrl_data_q <= '0;
      ctrl_rw_q   <= 1'b0;
      ctrl_en_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_addr_q <= ctrl_addr_d;
      ctrl_data_q <= ctrl_data_d;
      ctrl_rw_q   <= ctrl_rw_d;
      ctrl_en_q   <= ctrl_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end
`ifdef I2C_CMD_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`endif
endmodule

// File: doc/i2c_cmd_queue.md
Name: i2c_cmd_queue

Overview:
Upstream command sequencer for i2c_controller.
- Accepts I2C transaction requests (rw, 7-bit address, write byte) from a host over a valid/ready interface.
- Buffers requests in a FIFO and issues them one at a time on the controller's addr/data_in/rw/enable/ready handshake.
- Returns read bytes on a single-entry response channel.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles; used only with I2C_CMD_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  host command present
cmd_ready  out  1  FIFO can accept (not full)
cmd_rw  in  1  0=write, 1=read
cmd_addr  in  7  target slave address
cmd_wdata  in  8  write byte; ignored for reads
rsp_valid  out  1  read byte available
rsp_ready  in  1  host consumes response
rsp_data  out  8  read byte
rsp_addr  out  7  address the byte was read from
level  out  $clog2(DEPTH)+1  FIFO occupancy
busy  out  1  FSM not IDLE or FIFO non-empty
ctrl_addr  out  7  to controller addr
ctrl_data_in  out  8  to controller data_in
ctrl_rw  out  1  to controller rw
ctrl_enable  out  1  to controller enable
ctrl_ready  in  1  from controller ready
ctrl_data_out  in  8  from controller data_out
timeout_err  out  1  sticky watchdog flag; constant 0 without I2C_CMD_TIMEOUT_EN

Behaviour:
Reset (async, rst=1):
- FIFO empty; level=0; cmd_ready=1.
- rsp_valid=0; rsp_data=0; rsp_addr=0.
- ctrl_enable=0; ctrl_addr=0; ctrl_data_in=0; ctrl_rw=0.
- busy=0; timeout_err=0; FSM=IDLE.
- Reset mid-transfer drops ctrl_enable immediately and discards all queued and in-flight commands. No response is produced.

FIFO:
- Push on cmd_valid & cmd_ready. cmd_ready = !full.
- No bypass: a push while full is not accepted, even if a pop occurs in the same cycle.
- Pop happens only on the IDLE->ISSUE transition. Simultaneous push and pop leaves level unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.

FSM states:
- IDLE:
  - Go to ISSUE when all hold: FIFO non-empty, ctrl_ready=1, and (head.rw=0 or rsp_valid=0).
  - On that transition, pop head into ctrl_addr/ctrl_data_in/ctrl_rw (registered) and set ctrl_enable=1.
  - A read at head stalls in IDLE while the response slot is full. No reordering past it.
- ISSUE:
  - Hold ctrl_enable=1 and all ctrl_* stable until ctrl_ready is sampled 0.
  - Then clear ctrl_enable and go to WAIT.
- WAIT:
  - ctrl_enable=0.
  - When ctrl_ready is sampled 1, go to DONE.
- DONE (one cycle):
  - If ctrl_rw=1: capture ctrl_data_out into rsp_data and ctrl_addr into rsp_addr; set rsp_valid=1.
  - Return to IDLE.

Latency:
- Command accepted at edge E into an empty FIFO with the FSM in IDLE and ctrl_ready=1: ctrl_enable is high after edge E+1.
- Read completion: rsp_valid is high after the edge following the DONE entry.
- Back-to-back: the next command can issue 1 cycle after DONE (IDLE re-evaluates).

Response channel:
- rsp_valid clears on rsp_valid & rsp_ready.
- A consume and a new capture in the same cycle are impossible (read-issue gate).

busy = (state != IDLE) | (level != 0).

Optional Feature:
I2C_CMD_TIMEOUT_EN:
- Defined:
  - A counter runs in ISSUE and WAIT and clears on each state entry.
  - On reaching TIMEOUT_CYCLES: force ctrl_enable=0, set timeout_err=1 (sticky until rst), go to IDLE.
  - No response is produced for an aborted read.
- Not defined: no counter; timeout_err tied 0; FSM can wait indefinitely.

Decomposition:
- Package i2c_cmd_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - command struct {rw, addr[6:0], wdata[7:0]} (16 bits)
  - ADDR_W=7, DATA_W=8
- One natural sub-module: i2c_cmd_fifo. Synchronous FIFO parameterised by DEPTH and entry width, providing full/empty/level.

Test Plan:
- Single write addr=0x2A, wdata=0xAA with stub controller (ready low 20 cycles) -> ctrl_enable high one cycle after acceptance; ctrl_addr=0x2A, ctrl_data_in=0xAA, ctrl_rw=0; rsp_valid stays 0; busy falls after DONE.
- Read addr=0x2A, stub ctrl_data_out=0x55 -> rsp_valid=1, rsp_data=0x55, rsp_addr=0x2A; cleared the cycle after rsp_ready=1.
- Push 5 commands with DEPTH=4 while controller busy -> cmd_ready=0 after 4th; level=4; 5th held; all issued in push order with level decrementing.
- Two reads, rsp_ready=0 -> 2nd read not issued (ctrl_enable stays 0) until 1st response consumed; then issued and captured.
- Assert rst during WAIT with 2 entries queued -> ctrl_enable=0, level=0, rsp_valid=0 immediately; next command after release issues normally.
- With I2C_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, controller ready held 0 -> after 16 cycles timeout_err=1, ctrl_enable=0, FSM IDLE, no rsp_valid.
